// File: rtl/mtm_alu_serializer_if.sv
// Bus between the ALU core (master) and the serializer (slave): one result
// word plus control byte, a request strobe, and the serial line with busy.
interface mtm_alu_serializer_if #(
    parameter int N_DATA_BYTES = 4
);
    logic [8*N_DATA_BYTES-1:0] C;
    logic [7:0]                CTL;
    logic                      valid;
    logic                      sout;
    logic                      busy;

    modport master (output C, output CTL, output valid, input sout, input busy);
    modport slave  (input C, input CTL, input valid, output sout, output busy);
endinterface

// File: rtl/mtm_alu_serializer.sv
// Transmit side of the ALU serial link. Sends one ALU result as framed
// 11-bit bytes (start 0, type, D[7:0] MSB first, stop 1). Normal results go
// out as N_DATA_BYTES data bytes then the CTL byte; error results (CTL[7]=1)
// go out as the CTL byte only. sout and busy come straight from flops.
module mtm_alu_serializer #(
    parameter int N_DATA_BYTES = 4,
    parameter int GAP_BITS     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mtm_alu_serializer_if.slave  bus
);
    localparam int CW = 8 * N_DATA_BYTES;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        TYPE  = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        GAP   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CW-1:0]   c_q, c_d;
    logic [7:0]      ctl_q, ctl_d;
    logic            sout_q, sout_d;
    logic            busy_q, busy_d;

    logic            is_ctl;
    logic [7:0]      cur_byte;

    // Byte currently being shifted: the CTL byte is always the last one of a
    // frame (and the only one of an error frame), so is_ctl also means "last".
    always_comb begin
        is_ctl   = ctl_q[7] || (byte_cnt_q == 3'(N_DATA_BYTES));
        cur_byte = ctl_q;
        if (!is_ctl) begin
            for (int i = 0; i < N_DATA_BYTES; i++) begin
                if (byte_cnt_q == 3'(i)) cur_byte = c_q[8*(N_DATA_BYTES-1-i) +: 8];
            end
        end
    end

    // Next-state logic; sout_d/busy_d describe the bit shown in the next cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        c_d        = c_q;
        ctl_d      = ctl_q;
        sout_d     = 1'b1;
        busy_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    c_d        = bus.C;
                    ctl_d      = bus.CTL;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = START;
                    sout_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                state_d = TYPE;
                sout_d  = is_ctl;
                busy_d  = 1'b1;
            end
            TYPE: begin
                state_d   = DATA;
                bit_cnt_d = 3'd7;
                sout_d    = cur_byte[7];
                busy_d    = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (bit_cnt_q == 3'd0) begin
                    state_d = STOP;
                    sout_d  = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    sout_d    = cur_byte[bit_cnt_d];
                end
            end
            STOP: begin
                if (!is_ctl) begin
                    state_d    = START;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    bit_cnt_d  = '0;
                    sout_d     = 1'b0;
                    busy_d     = 1'b1;
                end else if (GAP_BITS > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_BITS - 1)) state_d = IDLE;
                else                                 gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and shadow registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            c_q        <= '0;
            ctl_q      <= '0;
            sout_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            c_q        <= c_d;
            ctl_q      <= ctl_d;
            sout_q     <= sout_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: constant frame vectors, hand-written corner
// sequences, and random frames checked against a bit/byte model and a
// behavioural receiver on sout.
module tb_mtm_alu_serializer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mtm_alu_serializer_if bus ();

    mtm_alu_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] c;
        logic [7:0]  ctl;
        logic [54:0] exp;   // right-aligned, first bit at exp[len-1]
        int          len;
    } vec_t;

    vec_t        vecs [5];
    logic        cap_q [$];
    logic        exp_bits [$];
    logic [9:0]  exp_bytes [$];
    logic [9:0]  rx_q [$];
    logic        rx_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: frame as a byte list, then each byte as 0,type,D7..D0,1.
    function automatic void build_model(input logic [31:0] c, input logic [7:0] ctl);
        logic [8:0] bytes [$];
        exp_bits.delete();
        exp_bytes.delete();
        if (!ctl[7]) begin
            for (int i = 3; i >= 0; i--) bytes.push_back({1'b0, c[8*i +: 8]});
        end
        bytes.push_back({1'b1, ctl});
        foreach (bytes[k]) begin
            exp_bytes.push_back({1'b1, bytes[k]});
            exp_bits.push_back(1'b0);
            exp_bits.push_back(bytes[k][8]);
            for (int b = 7; b >= 0; b--) exp_bits.push_back(bytes[k][b]);
            exp_bits.push_back(1'b1);
        end
    endfunction

    // Behavioural receiver: collects {stop, type, data} per received byte.
    initial begin
        int         pos;
        logic       typ;
        logic [7:0] d;
        pos = 0; typ = 1'b0; d = '0;
        forever begin
            @(negedge clk);
            if (!rx_en) pos = 0;
            else if (pos == 0) begin
                if (bus.sout == 1'b0) pos = 1;
            end else if (pos == 1) begin
                typ = bus.sout; pos = 2;
            end else if (pos < 10) begin
                d = {d[6:0], bus.sout}; pos++;
            end else begin
                rx_q.push_back({bus.sout, typ, d}); pos = 0;
            end
        end
    end

    // Called at a negedge: request for one cycle, returns at the first frame bit.
    task automatic pulse(input logic [31:0] c, input logic [7:0] ctl);
        bus.C     = c;
        bus.CTL   = ctl;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    // Records sout while busy (bounded); optional valid/rst injection at a bit.
    task automatic capture(input int inj_valid, input int inj_rst,
                           output logic [54:0] got, output int n);
        got = '0;
        n   = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            got = {got[53:0], bus.sout};
            cap_q.push_back(bus.sout);
            if (n == inj_valid) begin
                bus.C = 32'hDEADBEEF; bus.CTL = 8'h00; bus.valid = 1'b1;
            end else bus.valid = 1'b0;
            rst = (n == inj_rst);
            n++;
            @(negedge clk);
        end
        bus.valid = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        logic [54:0] got;
        int          n;
        int          bad;
        int          idle;
        logic [31:0] c;
        logic [7:0]  ctl;

        vecs[0] = '{32'h12345678, 8'h05,
            55'b00_00010010_1_00_00110100_1_00_01010110_1_00_01111000_1_01_00000101_1, 55};
        vecs[1] = '{32'hFFFFFFFF, 8'hC9, 55'b01_11001001_1, 11};
        vecs[2] = '{32'h00000000, 8'h00,
            55'b00_00000000_1_00_00000000_1_00_00000000_1_00_00000000_1_01_00000000_1, 55};
        vecs[3] = '{32'hFFFFFFFF, 8'h7F,
            55'b00_11111111_1_00_11111111_1_00_11111111_1_00_11111111_1_01_01111111_1, 55};
        vecs[4] = '{32'hA5A5A5A5, 8'h80, 55'b01_10000000_1, 11};

        rst = 1'b1; bus.valid = 1'b0; bus.C = '0; bus.CTL = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sout", 64'(bus.sout), 64'd1);
        chk("reset_busy", 64'(bus.busy), 64'd0);

        // Constant vectors
        foreach (vecs[i]) begin
            pulse(vecs[i].c, vecs[i].ctl);
            capture(-1, -1, got, n);
            chk($sformatf("vec%0d_len", i), 64'(n), 64'(vecs[i].len));
            chk($sformatf("vec%0d_bits", i), 64'(got), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_idle", i), 64'({bus.sout, bus.busy}), 64'b10);
            @(negedge clk);
        end

        // valid while busy is ignored
        pulse(vecs[0].c, vecs[0].ctl);
        capture(20, -1, got, n);
        chk("ignore_len", 64'(n), 64'd55);
        chk("ignore_bits", 64'(got), 64'(vecs[0].exp));
        bad = 0;
        repeat (60) begin
            if (bus.sout !== 1'b1 || bus.busy !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("ignore_no_second_frame", 64'(bad), 64'd0);

        // Back-to-back: request in the first cycle busy is low
        pulse(vecs[0].c, vecs[0].ctl);
        capture(-1, -1, got, n);
        chk("b2b_a_len", 64'(n), 64'd55);
        chk("b2b_a_bits", 64'(got), 64'(vecs[0].exp));
        chk("b2b_gap_sout", 64'(bus.sout), 64'd1);
        pulse(vecs[1].c, vecs[1].ctl);
        capture(-1, -1, got, n);
        chk("b2b_b_len", 64'(n), 64'd11);
        chk("b2b_b_bits", 64'(got), 64'(vecs[1].exp));
        @(negedge clk);

        // Reset at bit 30, then a clean frame
        pulse(vecs[0].c, vecs[0].ctl);
        capture(-1, 30, got, n);
        chk("rst_len", 64'(n), 64'd31);
        chk("rst_partial", 64'(got[30:0]), 64'(vecs[0].exp[54:24]));
        chk("rst_sout", 64'(bus.sout), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        pulse(vecs[0].c, vecs[0].ctl);
        capture(-1, -1, got, n);
        chk("after_rst_len", 64'(n), 64'd55);
        chk("after_rst_bits", 64'(got), 64'(vecs[0].exp));

        // Random frames through model and receiver
        rx_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            c    = $urandom;
            ctl  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ctl[7] = 1'b1; else ctl[7] = 1'b0;
            build_model(c, ctl);
            idle = $urandom_range(0, 2);
            repeat (idle) @(negedge clk);
            cap_q.delete();
            rx_q.delete();
            pulse(c, ctl);
            capture(-1, -1, got, n);
            chk($sformatf("rand%0d_len", t), 64'(n), 64'(exp_bits.size()));
            bad = 0;
            foreach (exp_bits[k]) if (k >= cap_q.size() || cap_q[k] !== exp_bits[k]) bad++;
            chk($sformatf("rand%0d_bit_errs", t), 64'(bad), 64'd0);
            chk($sformatf("rand%0d_rx_count", t), 64'(rx_q.size()), 64'(exp_bytes.size()));
            bad = 0;
            foreach (exp_bytes[k]) if (k >= rx_q.size() || rx_q[k] !== exp_bytes[k]) bad++;
            chk($sformatf("rand%0d_rx_errs", t), 64'(bad), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
